// File: rtl/filter_acc_unit_gen_if.sv
// filter_acc_unit_gen_if: sample-in / unit-result-out bundle of the filter accumulator
interface filter_acc_unit_gen_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32
);
    logic                  laser_start_i;
    logic                  adc_data_vld_i;
    logic [DATA_WIDTH-1:0] adc_data_i;
    logic [15:0]           filter_unit_len_i;
    logic [ACC_WIDTH-1:0]  acc_thr_high_i;
    logic [ACC_WIDTH-1:0]  acc_thr_low_i;
    logic                  filter_unit_vld_o;
    logic                  filter_acc_result_o;
    logic [ACC_WIDTH-1:0]  filter_acc_sum_o;
    logic [15:0]           filter_unit_cnt_o;

    modport master (
        output laser_start_i, adc_data_vld_i, adc_data_i, filter_unit_len_i,
               acc_thr_high_i, acc_thr_low_i,
        input  filter_unit_vld_o, filter_acc_result_o, filter_acc_sum_o, filter_unit_cnt_o
    );

    modport slave (
        input  laser_start_i, adc_data_vld_i, adc_data_i, filter_unit_len_i,
               acc_thr_high_i, acc_thr_low_i,
        output filter_unit_vld_o, filter_acc_result_o, filter_acc_sum_o, filter_unit_cnt_o
    );
endinterface

// File: rtl/filter_acc_unit_gen.sv
// filter_acc_unit_gen: sums ADC samples over fixed-length units and emits a hysteresis result per unit
module filter_acc_unit_gen #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32
) (
    input logic                  clk_i,
    input logic                  rst_i,
    filter_acc_unit_gen_if.slave bus
);
    typedef enum logic {IDLE, ACC} state_t;

    state_t               state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, sum_q, sum_n;
    logic [ACC_WIDTH:0]   raw;
    logic [15:0]          sample_cnt_q, len_q, len_eff, unit_cnt_q;
    logic                 vld_q, result_q, result_n, take, last;

    // run state follows laser_start: any low cycle returns to IDLE
    always_comb begin
        state_d = bus.laser_start_i ? ACC : IDLE;
    end

    // state register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // saturating sum, last-sample detect and hysteresis decision for the current sample
    always_comb begin
        len_eff  = (bus.filter_unit_len_i == 16'd0) ? 16'd1 : bus.filter_unit_len_i;
        raw      = {1'b0, acc_q} + {{(ACC_WIDTH + 1 - DATA_WIDTH){1'b0}}, bus.adc_data_i};
        sum_n    = raw[ACC_WIDTH] ? '1 : raw[ACC_WIDTH-1:0];
        take     = (state_q == ACC) && bus.laser_start_i && bus.adc_data_vld_i;
        last     = sample_cnt_q == len_q - 16'd1;
        result_n = result_q ? !(sum_n < bus.acc_thr_low_i) : (sum_n >= bus.acc_thr_high_i);
    end

    // accumulation and unit completion; dropping laser_start discards everything
    always_ff @(posedge clk_i) begin
        if (rst_i || !bus.laser_start_i) begin
            acc_q        <= '0;
            sum_q        <= '0;
            sample_cnt_q <= '0;
            len_q        <= '0;
            unit_cnt_q   <= '0;
            vld_q        <= 1'b0;
            result_q     <= 1'b0;
        end else begin
            vld_q <= take && last;
            if (state_q == IDLE) begin
                len_q <= len_eff;
            end else if (take) begin
                if (last) begin
                    acc_q        <= '0;
                    sample_cnt_q <= '0;
                    len_q        <= len_eff;
                    sum_q        <= sum_n;
                    unit_cnt_q   <= unit_cnt_q + 16'd1;
                    result_q     <= result_n;
                end else begin
                    acc_q        <= sum_n;
                    sample_cnt_q <= sample_cnt_q + 16'd1;
                end
            end
        end
    end

    assign bus.filter_unit_vld_o   = vld_q;
    assign bus.filter_acc_result_o = result_q;
    assign bus.filter_acc_sum_o    = sum_q;
    assign bus.filter_unit_cnt_o   = unit_cnt_q;
endmodule

// File: tb/tb_filter_acc_unit_gen.sv
// tb_filter_acc_unit_gen: directed stimulus with a unit-result scoreboard for filter_acc_unit_gen
module tb_filter_acc_unit_gen;
    typedef struct {
        logic [31:0] sum;
        logic        res;
        logic [15:0] cnt;
        int          cyc;
    } exp_t;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;
    exp_t sb[$];

    logic        m_run = 1'b0;
    logic        m_res = 1'b0;
    logic [15:0] m_cnt = '0;
    logic [15:0] m_sc = '0;
    logic [15:0] m_len = 16'd1;
    logic [31:0] m_acc = '0;

    filter_acc_unit_gen_if bus ();

    filter_acc_unit_gen dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic logic [15:0] eff(input logic [15:0] l);
        return (l == 16'd0) ? 16'd1 : l;
    endfunction

    // drive one cycle of inputs, advance the reference model, wait past the edge
    task automatic step(input logic r, input logic ls, input logic v, input logic [15:0] d);
        longint t;
        rst_i = r;
        bus.laser_start_i  = ls;
        bus.adc_data_vld_i = v;
        bus.adc_data_i     = d;
        if (r || !ls) begin
            m_run = 1'b0; m_res = 1'b0; m_cnt = '0; m_sc = '0; m_acc = '0;
        end else if (!m_run) begin
            m_run = 1'b1;
            m_len = eff(bus.filter_unit_len_i);
        end else if (v) begin
            t = longint'(m_acc) + longint'(d);
            if (t > 64'hFFFF_FFFF) t = 64'hFFFF_FFFF;
            if (m_sc == m_len - 16'd1) begin
                m_cnt = m_cnt + 16'd1;
                m_res = m_res ? !(t[31:0] < bus.acc_thr_low_i) : (t[31:0] >= bus.acc_thr_high_i);
                sb.push_back('{t[31:0], m_res, m_cnt, cyc + 1});
                m_acc = '0;
                m_sc  = '0;
                m_len = eff(bus.filter_unit_len_i);
            end else begin
                m_acc = t[31:0];
                m_sc  = m_sc + 16'd1;
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic smp(input logic [15:0] d);
        step(1'b0, 1'b1, 1'b1, d);
    endtask

    task automatic idle();
        step(1'b0, 1'b1, 1'b0, 16'd0);
    endtask

    task automatic drop();
        step(1'b0, 1'b0, 1'b0, 16'd0);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " vld"}, 32'(bus.filter_unit_vld_o), 32'd0);
        chk({tag, " result"}, 32'(bus.filter_acc_result_o), 32'd0);
        chk({tag, " sum"}, bus.filter_acc_sum_o, 32'd0);
        chk({tag, " cnt"}, 32'(bus.filter_unit_cnt_o), 32'd0);
    endtask

    // pop one expected unit per vld pulse and check contents and timing
    always @(negedge clk_i) begin
        if (bus.filter_unit_vld_o === 1'b1) begin
            compared++;
            assert (sb.size() != 0) else begin
                mismatched++;
                $error("FAIL unexpected_vld: observed vld at cycle %0d expected none", cyc);
            end
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                compared += 4;
                assert (cyc === e.cyc) else begin
                    mismatched++;
                    $error("FAIL vld_cycle: observed %0d expected %0d", cyc, e.cyc);
                end
                assert (bus.filter_acc_sum_o === e.sum) else begin
                    mismatched++;
                    $error("FAIL sum: observed 0x%0h expected 0x%0h", bus.filter_acc_sum_o, e.sum);
                end
                assert (bus.filter_acc_result_o === e.res) else begin
                    mismatched++;
                    $error("FAIL result: observed %0b expected %0b", bus.filter_acc_result_o, e.res);
                end
                assert (bus.filter_unit_cnt_o === e.cnt) else begin
                    mismatched++;
                    $error("FAIL cnt: observed %0d expected %0d", bus.filter_unit_cnt_o, e.cnt);
                end
            end
        end
    end

    initial begin
        bus.laser_start_i     = 1'b0;
        bus.adc_data_vld_i    = 1'b0;
        bus.adc_data_i        = '0;
        bus.filter_unit_len_i = 16'd4;
        bus.acc_thr_high_i    = 32'd100;
        bus.acc_thr_low_i     = 32'd50;
        step(1'b1, 1'b0, 1'b0, 16'd0);
        step(1'b1, 1'b1, 1'b1, 16'd9);
        chk_zero("reset");
        idle();
        smp(16'd10); smp(16'd20); smp(16'd30); smp(16'd40);
        smp(16'd20); smp(16'd20); smp(16'd20); smp(16'd20);
        smp(16'd10); smp(16'd10); smp(16'd10); smp(16'd10);
        idle();
        drop();
        bus.filter_unit_len_i = 16'd0;
        idle();
        for (int i = 0; i < 3; i++) begin
            smp(16'd7); idle(); idle();
        end
        smp(16'd7); smp(16'd7);
        drop();
        bus.filter_unit_len_i = 16'd65535;
        bus.acc_thr_high_i    = 32'hFFFE_0001;
        bus.acc_thr_low_i     = 32'd0;
        idle();
        smp(16'hFFFF);
        bus.filter_unit_len_i = 16'd2;
        for (int i = 1; i < 65535; i++) smp(16'hFFFF);
        smp(16'hFFFF);
        bus.filter_unit_len_i = 16'd1;
        smp(16'hFFFF);
        bus.acc_thr_high_i = 32'd10;
        bus.acc_thr_low_i  = 32'd200;
        smp(16'd5); smp(16'd50);
        drop();
        bus.filter_unit_len_i = 16'd8;
        bus.acc_thr_high_i    = 32'd100;
        bus.acc_thr_low_i     = 32'd50;
        idle();
        for (int i = 0; i < 8; i++) smp(16'd20);
        for (int i = 0; i < 5; i++) smp(16'd1);
        drop();
        chk_zero("laser_drop");
        idle();
        for (int i = 0; i < 7; i++) smp(16'd1);
        step(1'b0, 1'b0, 1'b1, 16'd1);
        chk_zero("drop_on_last");
        idle();
        for (int i = 0; i < 8; i++) smp(16'd2);
        drop();
        bus.filter_unit_len_i = 16'd2;
        bus.acc_thr_high_i    = 32'd1;
        bus.acc_thr_low_i     = 32'd1;
        idle();
        smp(16'd1); smp(16'd1); smp(16'd3);
        chk("pre_reset result", 32'(bus.filter_acc_result_o), 32'd1);
        step(1'b1, 1'b1, 1'b1, 16'd3);
        chk_zero("mid_reset");
        idle();
        smp(16'd4); smp(16'd4);
        idle(); idle(); idle();
        chk("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
